// File: rtl/axi_stream_pkt_arb.sv
// axi_stream_pkt_arb
// Packet-granular round-robin arbiter. Merges NUM_IN valid/ready streams onto
// one sink. A source that wins keeps the output until its eop beat transfers,
// so packets never interleave. The output is a single registered stage that
// sustains one beat per cycle, including across packet boundaries.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_mask[NUM_IN]          1 = source may win a new grant
//   i_val/sop/eop/err[n]    per-source stream controls
//   i_dat/i_mod/i_ctl       per-source payload, source n at [n*W +: W]
//   o_rdy[NUM_IN]           per-source ready (combinational)
//   o_val/sop/eop/err       merged stream controls (registered)
//   o_dat/o_mod/o_ctl       merged payload (registered)
//   o_src                   source index of the current output beat
//   i_rdy                   downstream ready
//   o_busy                  1 while a multi-beat packet owns the output
module axi_stream_pkt_arb #(
    parameter int unsigned NUM_IN   = 4,
    parameter int unsigned DAT_BYTS = 64,
    parameter int unsigned DAT_BITS = DAT_BYTS * 8,
    parameter int unsigned CTL_BITS = 8,
    parameter int unsigned MOD_BITS = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1,
    parameter int unsigned SEL_BITS = $clog2(NUM_IN)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [NUM_IN-1:0]            i_mask,
    input  logic [NUM_IN-1:0]            i_val,
    input  logic [NUM_IN-1:0]            i_sop,
    input  logic [NUM_IN-1:0]            i_eop,
    input  logic [NUM_IN-1:0]            i_err,
    input  logic [NUM_IN*DAT_BITS-1:0]   i_dat,
    input  logic [NUM_IN*MOD_BITS-1:0]   i_mod,
    input  logic [NUM_IN*CTL_BITS-1:0]   i_ctl,
    output logic [NUM_IN-1:0]            o_rdy,
    output logic                         o_val,
    output logic                         o_sop,
    output logic                         o_eop,
    output logic                         o_err,
    output logic [DAT_BITS-1:0]          o_dat,
    output logic [MOD_BITS-1:0]          o_mod,
    output logic [CTL_BITS-1:0]          o_ctl,
    output logic [SEL_BITS-1:0]          o_src,
    input  logic                         i_rdy,
    output logic                         o_busy
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SEL_BITS-1:0]   r_rr_ptr;
    logic [SEL_BITS-1:0]   w_rr_ptr_nxt;
    logic [SEL_BITS-1:0]   r_owner;
    logic [SEL_BITS-1:0]   w_owner_nxt;
    logic                  r_busy;

    logic [NUM_IN-1:0]     w_req;
    logic [SEL_BITS-1:0]   w_pick;
    logic                  w_any_req;
    logic [SEL_BITS-1:0]   w_sel;
    logic                  w_take;
    logic                  w_ld;

    logic                  r_val;
    logic                  r_sop;
    logic                  r_eop;
    logic                  r_err;
    logic [DAT_BITS-1:0]   r_dat;
    logic [MOD_BITS-1:0]   r_mod;
    logic [CTL_BITS-1:0]   r_ctl;
    logic [SEL_BITS-1:0]   r_src;

    // Next index after x, wrapping at NUM_IN (works for non power-of-two NUM_IN).
    function automatic logic [SEL_BITS-1:0] f_wrap_inc(input logic [SEL_BITS-1:0] x);
        return (x == SEL_BITS'(NUM_IN - 1)) ? '0 : x + SEL_BITS'(1);
    endfunction

    // Output stage can take a new beat when empty or being drained this cycle.
    assign w_ld  = !r_val || i_rdy;
    assign w_req = i_val & i_mask;

    // Round-robin pick: first requester at or after r_rr_ptr.
    always_comb begin
        int unsigned idx;
        w_pick    = '0;
        w_any_req = 1'b0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            idx = (32'(r_rr_ptr) + i) % NUM_IN;
            if (!w_any_req && w_req[SEL_BITS'(idx)]) begin
                w_any_req = 1'b1;
                w_pick    = SEL_BITS'(idx);
            end
        end
    end

    // Next-state, grant and ready generation.
    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_owner_nxt  = r_owner;
        w_sel        = w_pick;
        w_take       = 1'b0;
        o_rdy        = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    o_rdy[w_pick] = w_ld;
                    w_take        = w_ld;
                    if (w_ld) begin
                        if (i_eop[w_pick]) begin
                            w_rr_ptr_nxt = f_wrap_inc(w_pick);
                        end else begin
                            w_state_nxt = ST_LOCKED;
                            w_owner_nxt = w_pick;
                        end
                    end
                end
            end
            ST_LOCKED: begin
                // Mask is not consulted here so a packet is never truncated.
                w_sel          = r_owner;
                o_rdy[r_owner] = w_ld;
                w_take         = w_ld && i_val[r_owner];
                if (w_take && i_eop[r_owner]) begin
                    w_state_nxt  = ST_IDLE;
                    w_rr_ptr_nxt = f_wrap_inc(r_owner);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Arbitration state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_owner  <= w_owner_nxt;
            r_busy   <= (w_state_nxt == ST_LOCKED);
        end
    end

    // Output register: loads the granted beat, or empties when nothing is taken.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_val <= 1'b0;
            r_sop <= 1'b0;
            r_eop <= 1'b0;
            r_err <= 1'b0;
            r_dat <= '0;
            r_mod <= '0;
            r_ctl <= '0;
            r_src <= '0;
        end else if (w_ld) begin
            r_val <= w_take;
            if (w_take) begin
                r_sop <= i_sop[w_sel];
                r_eop <= i_eop[w_sel];
                r_err <= i_err[w_sel];
                r_dat <= i_dat[w_sel*DAT_BITS +: DAT_BITS];
                r_mod <= i_mod[w_sel*MOD_BITS +: MOD_BITS];
                r_ctl <= i_ctl[w_sel*CTL_BITS +: CTL_BITS];
                r_src <= w_sel;
            end else begin
                r_sop <= 1'b0;
                r_eop <= 1'b0;
                r_err <= 1'b0;
            end
        end
    end

    assign o_val  = r_val;
    assign o_sop  = r_sop;
    assign o_eop  = r_eop;
    assign o_err  = r_err;
    assign o_dat  = r_dat;
    assign o_mod  = r_mod;
    assign o_ctl  = r_ctl;
    assign o_src  = r_src;
    assign o_busy = r_busy;

endmodule

// File: tb/tb_axi_stream_pkt_arb.sv
// Testbench for axi_stream_pkt_arb: per-source beat queues feed the DUT, the
// expected merged order is pushed to a scoreboard as packets are queued, and
// every output transfer is popped and compared.
module tb_axi_stream_pkt_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 512;
    localparam int unsigned CW = 8;
    localparam int unsigned MW = 6;
    localparam int unsigned SW = 2;

    typedef struct packed {
        logic [SW-1:0] src;
        logic          sop;
        logic          eop;
        logic          err;
        logic [MW-1:0] mod;
        logic [CW-1:0] ctl;
        logic [DW-1:0] dat;
    } beat_t;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    tb_mask;
    logic [N-1:0]    tb_val;
    logic [N-1:0]    tb_sop;
    logic [N-1:0]    tb_eop;
    logic [N-1:0]    tb_err;
    logic [N*DW-1:0] tb_dat;
    logic [N*MW-1:0] tb_mod;
    logic [N*CW-1:0] tb_ctl;
    logic [N-1:0]    o_rdy;
    logic            o_val;
    logic            o_sop;
    logic            o_eop;
    logic            o_err;
    logic [DW-1:0]   o_dat;
    logic [MW-1:0]   o_mod;
    logic [CW-1:0]   o_ctl;
    logic [SW-1:0]   o_src;
    logic            tb_rdy;
    logic            o_busy;

    beat_t srcq[N][$];
    beat_t expq[$];
    int    nchk    = 0;
    int    npass   = 0;
    int    nfail   = 0;
    int    cur_run = 0;
    int    max_run = 0;
    bit    rand_rdy = 1'b0;

    axi_stream_pkt_arb dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_mask  (tb_mask),
        .i_val   (tb_val),
        .i_sop   (tb_sop),
        .i_eop   (tb_eop),
        .i_err   (tb_err),
        .i_dat   (tb_dat),
        .i_mod   (tb_mod),
        .i_ctl   (tb_ctl),
        .o_rdy   (o_rdy),
        .o_val   (o_val),
        .o_sop   (o_sop),
        .o_eop   (o_eop),
        .o_err   (o_err),
        .o_dat   (o_dat),
        .o_mod   (o_mod),
        .o_ctl   (o_ctl),
        .o_src   (o_src),
        .i_rdy   (tb_rdy),
        .o_busy  (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk_beat(input int src, input bit sop, input bit eop, input int md);
        beat_t b;
        b.src = SW'(src);
        b.sop = sop;
        b.eop = eop;
        b.err = eop ? 1'($urandom_range(0, 1)) : 1'b0;
        b.mod = eop ? MW'(md) : '0;
        b.ctl = CW'($urandom);
        for (int w = 0; w < int'(DW / 32); w++) b.dat[w*32 +: 32] = $urandom;
        return b;
    endfunction

    // Queue one packet on a source; optionally record it as the next expected output.
    task automatic add_pkt(input int src, input int nb, input int last_mod, input bit expect_it);
        beat_t b;
        for (int k = 0; k < nb; k++) begin
            b = mk_beat(src, (k == 0), (k == nb - 1), last_mod);
            srcq[src].push_back(b);
            if (expect_it) expq.push_back(b);
        end
    endtask

    task automatic wait_drain(input string tag, input int limit);
        int t;
        t = 0;
        while (expq.size() != 0 && t < limit) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_drain"}, 64'(expq.size()), 64'd0);
    endtask

    // Source driver and output monitor: sample at the edge, drive 1 time unit later.
    initial begin
        logic [N-1:0] fire;
        beat_t        obs;
        beat_t        exp;
        beat_t        hd;
        forever begin
            @(posedge clk);
            fire = tb_val & o_rdy & {N{rst_n}};
            if (rst_n && o_val && tb_rdy) begin
                obs.src = o_src;
                obs.sop = o_sop;
                obs.eop = o_eop;
                obs.err = o_err;
                obs.mod = o_mod;
                obs.ctl = o_ctl;
                obs.dat = o_dat;
                nchk++;
                assert (expq.size() != 0) npass++;
                else begin
                    nfail++;
                    $error("FAIL unexpected_beat observed_src=%0d expected=none", o_src);
                end
                if (expq.size() != 0) begin
                    exp = expq.pop_front();
                    nchk++;
                    assert (obs === exp) npass++;
                    else begin
                        nfail++;
                        $error("FAIL beat observed=%h expected=%h", obs, exp);
                    end
                end
            end
            if (rst_n && o_val) begin
                cur_run++;
                if (cur_run > max_run) max_run = cur_run;
            end else begin
                cur_run = 0;
            end
            #1;
            for (int n = 0; n < int'(N); n++) begin
                if (fire[n] && srcq[n].size() > 0) void'(srcq[n].pop_front());
            end
            for (int n = 0; n < int'(N); n++) begin
                if (srcq[n].size() > 0) begin
                    hd                 = srcq[n][0];
                    tb_val[n]          = 1'b1;
                    tb_sop[n]          = hd.sop;
                    tb_eop[n]          = hd.eop;
                    tb_err[n]          = hd.err;
                    tb_dat[n*DW +: DW] = hd.dat;
                    tb_mod[n*MW +: MW] = hd.mod;
                    tb_ctl[n*CW +: CW] = hd.ctl;
                end else begin
                    tb_val[n] = 1'b0;
                end
            end
            tb_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        rst_n   = 1'b0;
        tb_mask = 4'hF;
        tb_val  = '0;
        tb_sop  = '0;
        tb_eop  = '0;
        tb_err  = '0;
        tb_dat  = '0;
        tb_mod  = '0;
        tb_ctl  = '0;
        tb_rdy  = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_val",  64'(o_val),  64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_src",  64'(o_src),  64'd0);
        chk("rst_dat",  64'(|o_dat), 64'd0);
        chk("rst_sop_eop", 64'({o_sop, o_eop, o_err}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_rdy_none", 64'(o_rdy), 64'd0);

        // All four sources, 2-beat packets: order 0,1,2,3 with no gaps
        max_run = 0;
        for (int s = 0; s < 4; s++) add_pkt(s, 2, 0, 1'b1);
        wait_drain("all4", 100);
        chk("all4_run", 64'(max_run), 64'd8);
        chk("all4_busy", 64'(o_busy), 64'd0);

        // src2 long packet locks out src0 that arrives one cycle later
        max_run = 0;
        add_pkt(2, 5, 0, 1'b1);
        @(negedge clk);
        add_pkt(0, 2, 0, 1'b1);
        repeat (2) @(negedge clk);
        chk("lock_busy", 64'(o_busy), 64'd1);
        chk("lock_rdy0", 64'(o_rdy[0]), 64'd0);
        @(negedge clk);
        chk("lock_rdy0_b", 64'(o_rdy[0]), 64'd0);
        wait_drain("lock", 100);
        chk("lock_run", 64'(max_run), 64'd7);

        // Random backpressure, 130-byte packets (3 beats, mod=2) from src1 and src3
        rand_rdy = 1'b1;
        add_pkt(1, 3, 2, 1'b1);
        add_pkt(3, 3, 2, 1'b1);
        add_pkt(1, 3, 2, 1'b1);
        add_pkt(3, 3, 2, 1'b1);
        wait_drain("bp", 500);
        rand_rdy = 1'b0;
        repeat (2) @(negedge clk);

        // Mask: src0 masked throughout; src1 masked mid-packet completes, no re-grant
        tb_mask = 4'b1110;
        add_pkt(0, 2, 0, 1'b0);
        add_pkt(1, 4, 0, 1'b1);
        repeat (2) @(negedge clk);
        chk("mask_busy", 64'(o_busy), 64'd1);
        tb_mask = 4'b1100;
        chk("mask_rdy0", 64'(o_rdy[0]), 64'd0);
        add_pkt(1, 2, 0, 1'b0);
        wait_drain("mask", 60);
        repeat (6) @(negedge clk);
        chk("mask_rdy_off", 64'(o_rdy[1:0]), 64'd0);
        chk("mask_val", 64'(o_val), 64'd0);
        chk("mask_src0_left", 64'(srcq[0].size()), 64'd2);
        chk("mask_src1_left", 64'(srcq[1].size()), 64'd2);
        srcq[0].delete();
        srcq[1].delete();
        repeat (2) @(negedge clk);
        tb_mask = 4'hF;

        // Single-beat packets from src0/src1 every cycle: strict alternation
        max_run = 0;
        for (int k = 0; k < 4; k++) begin
            add_pkt(0, 1, 0, 1'b1);
            add_pkt(1, 1, 0, 1'b1);
        end
        wait_drain("alt", 100);
        chk("alt_run", 64'(max_run), 64'd8);

        // Reset in the middle of a src0 packet
        add_pkt(0, 3, 0, 1'b0);
        expq.push_back(srcq[0][0]);
        wait_drain("rstmid_pre", 50);
        chk("rstmid_busy", 64'(o_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_val", 64'(o_val), 64'd0);
        chk("rstmid_busy0", 64'(o_busy), 64'd0);
        srcq[0].delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        add_pkt(1, 2, 0, 1'b1);
        add_pkt(3, 2, 0, 1'b1);
        wait_drain("rstmid_post", 100);

        repeat (3) @(negedge clk);
        chk("end_val", 64'(o_val), 64'd0);
        chk("end_busy", 64'(o_busy), 64'd0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
